// File: rtl/move_sched.sv
// Two-player movement scheduler: decodes active-low keys and time-shares one clamped,
// collision-checked position update between the players during the EOF..SOF blanking window.
// Define MOVE_SCHED_DIAG_EN to accept one-horizontal-plus-one-vertical key combinations as diagonals.
module move_sched #(
  parameter int HACTIVE  = 800,
  parameter int VACTIVE  = 600,
  parameter int STEP_DIV = 3000,
  parameter int STEP     = 1,
  parameter int MIN_DIST = 32,
  parameter int P0_X0    = 100,
  parameter int P0_Y0    = 300,
  parameter int P1_X0    = 700,
  parameter int P1_Y0    = 300
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               SOF,
  input  logic               EOF,
  input  logic [3:0]         key0,
  input  logic [3:0]         key1,
  output logic signed [10:0] p0x,
  output logic signed [10:0] p0y,
  output logic signed [10:0] p1x,
  output logic signed [10:0] p1y,
  output logic [1:0]         grant,
  output logic               blocked,
  output logic               window
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] COUNT  = 2'd1;
  localparam logic [1:0] EVAL   = 2'd2;
  localparam logic [1:0] COMMIT = 2'd3;

  localparam int CNT_W = $clog2(STEP_DIV);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic signed [11:0] STEP_S   = 12'(STEP);
  localparam logic signed [11:0] X_MAX    = 12'(HACTIVE - 1);
  localparam logic signed [11:0] Y_MAX    = 12'(VACTIVE - 1);
  localparam logic signed [11:0] MIN_S    = 12'(MIN_DIST);

  // Returns {req, dx[1:0], dy[1:0]}; dx/dy are -1/0/+1 in 2-bit two's complement (+y is down).
  function automatic logic [4:0] decode_keys(input logic [3:0] k);
    logic [4:0] r;
    case (~k)
      4'b0001: r = {1'b1, 2'b01, 2'b00};
      4'b0010: r = {1'b1, 2'b00, 2'b01};
      4'b0100: r = {1'b1, 2'b00, 2'b11};
      4'b1000: r = {1'b1, 2'b11, 2'b00};
`ifdef MOVE_SCHED_DIAG_EN
      4'b0011: r = {1'b1, 2'b01, 2'b01};
      4'b0101: r = {1'b1, 2'b01, 2'b11};
      4'b1010: r = {1'b1, 2'b11, 2'b01};
      4'b1100: r = {1'b1, 2'b11, 2'b11};
`endif
      default: r = 5'b0_00_00;
    endcase
    return r;
  endfunction

  logic [1:0]         state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               window_r, rr_r, sel_r;
  logic [1:0]         dx_r, dy_r, grant_r;
  logic               blocked_r;
  logic signed [10:0] p0x_r, p0y_r, p1x_r, p1y_r;

  logic [4:0]         d0_s, d1_s;
  logic               sel_s;
  logic signed [11:0] cur_x_s, cur_y_s, oth_x_s, oth_y_s;
  logic signed [11:0] step_x_s, step_y_s, sum_x_s, sum_y_s, cand_x_s, cand_y_s;
  logic signed [11:0] diff_x_s, diff_y_s, adx_s, ady_s;
  logic               overlap_s, same_s;

  // Arbitration and candidate position / collision evaluation.
  always_comb begin
    d0_s  = decode_keys(key0);
    d1_s  = decode_keys(key1);
    sel_s = (d0_s[4] && d1_s[4]) ? rr_r : d1_s[4];

    cur_x_s = sel_r ? {p1x_r[10], p1x_r} : {p0x_r[10], p0x_r};
    cur_y_s = sel_r ? {p1y_r[10], p1y_r} : {p0y_r[10], p0y_r};
    oth_x_s = sel_r ? {p0x_r[10], p0x_r} : {p1x_r[10], p1x_r};
    oth_y_s = sel_r ? {p0y_r[10], p0y_r} : {p1y_r[10], p1y_r};

    case (dx_r)
      2'b01:   step_x_s = STEP_S;
      2'b11:   step_x_s = -STEP_S;
      default: step_x_s = 12'sd0;
    endcase
    case (dy_r)
      2'b01:   step_y_s = STEP_S;
      2'b11:   step_y_s = -STEP_S;
      default: step_y_s = 12'sd0;
    endcase

    sum_x_s = cur_x_s + step_x_s;
    sum_y_s = cur_y_s + step_y_s;
    // Each axis is clamped on its own: an out-of-range axis simply keeps its value.
    if (sum_x_s < 12'sd0 || sum_x_s > X_MAX) cand_x_s = cur_x_s;
    else                                     cand_x_s = sum_x_s;
    if (sum_y_s < 12'sd0 || sum_y_s > Y_MAX) cand_y_s = cur_y_s;
    else                                     cand_y_s = sum_y_s;

    diff_x_s  = cand_x_s - oth_x_s;
    diff_y_s  = cand_y_s - oth_y_s;
    adx_s     = (diff_x_s < 12'sd0) ? -diff_x_s : diff_x_s;
    ady_s     = (diff_y_s < 12'sd0) ? -diff_y_s : diff_y_s;
    overlap_s = (adx_s < MIN_S) && (ady_s < MIN_S);
    same_s    = (cand_x_s == cur_x_s) && (cand_y_s == cur_y_s);
  end

  // Window flag, prescaler FSM, arbiter pointer and the registered player positions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      window_r  <= 1'b0;
      rr_r      <= 1'b0;
      sel_r     <= 1'b0;
      dx_r      <= 2'b00;
      dy_r      <= 2'b00;
      grant_r   <= 2'b00;
      blocked_r <= 1'b0;
      p0x_r     <= 11'(P0_X0);
      p0y_r     <= 11'(P0_Y0);
      p1x_r     <= 11'(P1_X0);
      p1y_r     <= 11'(P1_Y0);
    end else begin
      grant_r   <= 2'b00;
      blocked_r <= 1'b0;
      if (SOF)      window_r <= 1'b0;
      else if (EOF) window_r <= 1'b1;
      else          window_r <= window_r;

      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (window_r) state_r <= COUNT;
          else          state_r <= IDLE;
        end
        COUNT: begin
          if (!window_r) begin
            state_r <= IDLE;
          end else if (cnt_r == CNT_LAST) begin
            cnt_r   <= '0;
            state_r <= EVAL;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        EVAL: begin
          if (d0_s[4] || d1_s[4]) begin
            sel_r   <= sel_s;
            dx_r    <= sel_s ? d1_s[3:2] : d0_s[3:2];
            dy_r    <= sel_s ? d1_s[1:0] : d0_s[1:0];
            state_r <= COMMIT;
          end else begin
            state_r <= COUNT;
          end
        end
        COMMIT: begin
          rr_r <= ~sel_r;
          if (same_s) begin
            blocked_r <= 1'b0;
          end else if (overlap_s) begin
            blocked_r <= 1'b1;
          end else if (sel_r) begin
            p1x_r   <= cand_x_s[10:0];
            p1y_r   <= cand_y_s[10:0];
            grant_r <= 2'b10;
          end else begin
            p0x_r   <= cand_x_s[10:0];
            p0y_r   <= cand_y_s[10:0];
            grant_r <= 2'b01;
          end
          state_r <= window_r ? COUNT : IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign p0x     = p0x_r;
  assign p0y     = p0y_r;
  assign p1x     = p1x_r;
  assign p1y     = p1y_r;
  assign grant   = grant_r;
  assign blocked = blocked_r;
  assign window  = window_r;

endmodule

// File: tb/tb_move_sched.sv
// Scoreboard bench for move_sched: a per-tick model pushes expected grant/blocked events,
// a negedge monitor pops them as pulses appear and checks positions stay put otherwise.
module tb_move_sched;
  localparam int SD = 4;
  localparam int HA = 800;
  localparam int VA = 600;
  localparam int MD = 32;
  localparam logic [3:0] KF = 4'b1111;

  logic clk = 1'b0;
  logic reset_n, sof, eof;
  logic [3:0] key0, key1;
  logic signed [10:0] p0x, p0y, p1x, p1y;
  logic [1:0] grant;
  logic blocked, window;

  always #5 clk = ~clk;

  move_sched #(.STEP_DIV(SD)) dut (
    .clk(clk), .reset_n(reset_n), .SOF(sof), .EOF(eof), .key0(key0), .key1(key1),
    .p0x(p0x), .p0y(p0y), .p1x(p1x), .p1y(p1y),
    .grant(grant), .blocked(blocked), .window(window)
  );

  typedef struct {
    logic [1:0] g;
    logic       b;
    int         p0x, p0y, p1x, p1y;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  m_p0x, m_p0y, m_p1x, m_p1y;
  bit  m_rr;
  int  s_p0x, s_p0y, s_p1x, s_p1y;
  int  n_g0 = 0, n_g1 = 0, n_blk = 0;

  task automatic model_reset();
    m_p0x = 100; m_p0y = 300; m_p1x = 700; m_p1y = 300; m_rr = 1'b0;
    s_p0x = 100; s_p0y = 300; s_p1x = 700; s_p1y = 300;
    exp_q.delete();
  endtask

  task automatic decode(input logic [3:0] k, output bit req, output int dx, output int dy);
    bit r, d, u, l;
    int n;
    r = !k[0]; d = !k[1]; u = !k[2]; l = !k[3];
    n = int'(r) + int'(d) + int'(u) + int'(l);
    req = 1'b0; dx = 0; dy = 0;
    if (n == 1) begin
      req = 1'b1;
      dx = r ? 1 : (l ? -1 : 0);
      dy = d ? 1 : (u ? -1 : 0);
    end
`ifdef MOVE_SCHED_DIAG_EN
    else if (n == 2 && (r ^ l) && (d ^ u)) begin
      req = 1'b1;
      dx = r ? 1 : -1;
      dy = d ? 1 : -1;
    end
`endif
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // One movement tick of the reference model; pushes the event the DUT should emit.
  task automatic model_tick(input logic [3:0] k0, input logic [3:0] k1);
    bit r0, r1, sel;
    int dx0, dy0, dx1, dy1, cx, cy, ox, oy, nx, ny;
    ev_t e;
    decode(k0, r0, dx0, dy0);
    decode(k1, r1, dx1, dy1);
    if (!r0 && !r1) return;
    sel  = (r0 && r1) ? m_rr : r1;
    m_rr = !sel;
    cx = sel ? m_p1x : m_p0x;  cy = sel ? m_p1y : m_p0y;
    ox = sel ? m_p0x : m_p1x;  oy = sel ? m_p0y : m_p1y;
    nx = cx + (sel ? dx1 : dx0);
    ny = cy + (sel ? dy1 : dy0);
    if (nx < 0 || nx > HA - 1) nx = cx;
    if (ny < 0 || ny > VA - 1) ny = cy;
    if (nx == cx && ny == cy) return;
    if (iabs(nx - ox) < MD && iabs(ny - oy) < MD) begin
      e.g = 2'b00; e.b = 1'b1;
    end else begin
      e.b = 1'b0;
      if (sel) begin m_p1x = nx; m_p1y = ny; e.g = 2'b10; end
      else     begin m_p0x = nx; m_p0y = ny; e.g = 2'b01; end
    end
    e.p0x = m_p0x; e.p0y = m_p0y; e.p1x = m_p1x; e.p1y = m_p1y;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse must match the next expected event; positions never move otherwise.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (grant !== 2'b00 || blocked !== 1'b0) begin
        if (grant == 2'b01) n_g0++;
        if (grant == 2'b10) n_g1++;
        if (blocked) n_blk++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event: got grant=%b blocked=%b, required no pulse", grant, blocked);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (grant !== e.g || blocked !== e.b || int'(p0x) != e.p0x || int'(p0y) != e.p0y ||
              int'(p1x) != e.p1x || int'(p1y) != e.p1y) begin
            failures++;
            $display("FAIL event: got g=%b b=%b p0=(%0d,%0d) p1=(%0d,%0d), required g=%b b=%b p0=(%0d,%0d) p1=(%0d,%0d)",
                     grant, blocked, p0x, p0y, p1x, p1y, e.g, e.b, e.p0x, e.p0y, e.p1x, e.p1y);
          end
          s_p0x = e.p0x; s_p0y = e.p0y; s_p1x = e.p1x; s_p1y = e.p1y;
        end
      end
      checks++;
      if (int'(p0x) != s_p0x || int'(p0y) != s_p0y || int'(p1x) != s_p1x || int'(p1y) != s_p1y) begin
        failures++;
        $display("FAIL position_hold: got p0=(%0d,%0d) p1=(%0d,%0d), required p0=(%0d,%0d) p1=(%0d,%0d)",
                 p0x, p0y, p1x, p1y, s_p0x, s_p0y, s_p1x, s_p1y);
      end
    end
  end

  // A window of exactly n ticks: with STEP_DIV=4 tick i commits 6 cycles after tick i-1.
  task automatic run_window(input logic [3:0] k0, input logic [3:0] k1, input int n);
    @(negedge clk);
    key0 = k0; key1 = k1;
    for (int i = 0; i < n; i++) model_tick(k0, k1);
    eof = 1'b1;
    @(negedge clk);
    eof = 1'b0;
    checks++;
    if (window !== 1'b1) begin
      failures++;
      $display("FAIL window_open: got %b, required 1", window);
    end
    repeat (6 * n) @(negedge clk);
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
    repeat (8) @(negedge clk);
    key0 = KF; key1 = KF;
    checks++;
    if (window !== 1'b0) begin
      failures++;
      $display("FAIL window_closed: got %b, required 0", window);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events: got %0d still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic move_to(input bit pl, input int tx, input int ty);
    int cx, cy;
    cx = pl ? m_p1x : m_p0x;
    cy = pl ? m_p1y : m_p0y;
    if (tx != cx) begin
      if (pl) run_window(KF, (tx > cx) ? 4'b1110 : 4'b0111, iabs(tx - cx));
      else    run_window((tx > cx) ? 4'b1110 : 4'b0111, KF, iabs(tx - cx));
    end
    if (ty != cy) begin
      if (pl) run_window(KF, (ty > cy) ? 4'b1101 : 4'b1011, iabs(ty - cy));
      else    run_window((ty > cy) ? 4'b1101 : 4'b1011, KF, iabs(ty - cy));
    end
  endtask

  task automatic check_pos(input string name, input int ax, input int ay, input int ex, input int ey);
    checks++;
    if (ax != ex || ay != ey) begin
      failures++;
      $display("FAIL %s: got (%0d,%0d), required (%0d,%0d)", name, ax, ay, ex, ey);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sof = 1'b0; eof = 1'b0; key0 = KF; key1 = KF;
    model_reset();
    repeat (3) @(negedge clk);
    check_pos("reset_p0", int'(p0x), int'(p0y), 100, 300);
    check_pos("reset_p1", int'(p1x), int'(p1y), 700, 300);
    checks++;
    if (grant !== 2'b00 || blocked !== 1'b0 || window !== 1'b0) begin
      failures++;
      $display("FAIL reset_pulses: got grant=%b blocked=%b window=%b, required 00 0 0", grant, blocked, window);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_idle();
    run_window(KF, KF, 3);
    run_window(KF, KF, 2);
    check_pos("idle_p0", int'(p0x), int'(p0y), 100, 300);
  endtask

  task automatic test_round_robin();
    int g0, g1;
    g0 = n_g0; g1 = n_g1;
    run_window(4'b1101, 4'b1011, 4);
    checks++;
    if (n_g0 - g0 != 2 || n_g1 - g1 != 2) begin
      failures++;
      $display("FAIL rr_counts: got %0d/%0d grants, required 2/2", n_g0 - g0, n_g1 - g1);
    end
    check_pos("rr_p0", int'(p0x), int'(p0y), 100, 302);
    check_pos("rr_p1", int'(p1x), int'(p1y), 700, 298);
  endtask

  task automatic test_single_move();
    int g0;
    g0 = n_g0;
    run_window(4'b1110, KF, 3);
    checks++;
    if (n_g0 - g0 != 3) begin
      failures++;
      $display("FAIL single_grants: got %0d, required 3", n_g0 - g0);
    end
    repeat (20) @(negedge clk);
    check_pos("single_p0", int'(p0x), int'(p0y), 103, 302);
    check_pos("single_p1", int'(p1x), int'(p1y), 700, 298);
  endtask

  task automatic test_clamp();
    int g, b;
    move_to(1'b1, 799, 298);
    g = n_g0 + n_g1; b = n_blk;
    run_window(KF, 4'b1110, 3);
    check_pos("clamp_p1x", int'(p1x), 0, 799, 0);
    move_to(1'b0, 103, 0);
    run_window(4'b1011, KF, 3);
    check_pos("clamp_p0y", 0, int'(p0y), 0, 0);
    checks++;
    if (n_g0 + n_g1 - g != 302 || n_blk != b) begin
      failures++;
      $display("FAIL clamp_pulses: got %0d grants %0d blocks, required 302 0", n_g0 + n_g1 - g, n_blk - b);
    end
  endtask

  task automatic test_collision();
    int b, g1;
    move_to(1'b0, 100, 300);
    move_to(1'b1, 132, 300);
    check_pos("coll_setup_p1", int'(p1x), int'(p1y), 132, 300);
    b = n_blk;
    run_window(4'b1110, KF, 1);
    checks++;
    if (n_blk - b != 1) begin
      failures++;
      $display("FAIL collision_blocked: got %0d pulses, required 1", n_blk - b);
    end
    check_pos("coll_p0", int'(p0x), int'(p0y), 100, 300);
    g1 = n_g1;
    run_window(KF, 4'b1110, 1);
    checks++;
    if (n_g1 - g1 != 1) begin
      failures++;
      $display("FAIL collision_after: got %0d p1 grants, required 1", n_g1 - g1);
    end
    check_pos("coll_p1", int'(p1x), int'(p1y), 133, 300);
  endtask

  task automatic test_diag();
    run_window(4'b1100, KF, 1);
`ifdef MOVE_SCHED_DIAG_EN
    check_pos("diag_p0", int'(p0x), int'(p0y), 101, 301);
`else
    check_pos("diag_p0", int'(p0x), int'(p0y), 100, 300);
`endif
    run_window(4'b0110, KF, 1);
    check_pos("opposite_p0", int'(p0x), int'(p0y), m_p0x, m_p0y);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    key0 = 4'b1110;
    eof = 1'b1;
    @(negedge clk);
    eof = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_pos("async_p0", int'(p0x), int'(p0y), 100, 300);
    check_pos("async_p1", int'(p1x), int'(p1y), 700, 300);
    checks++;
    if (window !== 1'b0 || grant !== 2'b00) begin
      failures++;
      $display("FAIL async_flags: got window=%b grant=%b, required 0 00", window, grant);
    end
    key0 = KF;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check_pos("post_reset_p0", int'(p0x), int'(p0y), 100, 300);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_round_robin();
    test_single_move();
    test_clamp();
    test_collision();
    test_diag();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/move_sched.md
# move_sched

Per-frame movement scheduler for the two Bomberman players. It decodes both players' active-low key vectors and shares one position-update datapath between them with a round-robin arbiter. Updates happen only in the blanking window between EOF and SOF, paced by a prescaler. Each move is clamped to the screen, and a move that would overlap the other player is refused. The outputs are the registered player coordinates consumed by the sprite/display logic.

## Interface
- HACTIVE, 800, horizontal active size; legal x range 0..HACTIVE-1
- VACTIVE, 600, vertical active size; legal y range 0..VACTIVE-1
- STEP_DIV, 3000, blanking-window cycles per movement tick (≥4)
- STEP, 1, pixels moved per granted update, per axis
- MIN_DIST, 32, minimum separation; overlap when both |dx|<MIN_DIST and |dy|<MIN_DIST
- P0_X0/P0_Y0, 100/300, player 0 reset position
- P1_X0/P1_Y0, 700/300, player 1 reset position
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- SOF  in  1  start-of-frame pulse; closes the update window
- EOF  in  1  end-of-frame pulse; opens the update window
- key0  in  4  player 0 keys, active-low: bit0 right, bit1 down, bit2 up, bit3 left
- key1  in  4  player 1 keys, same encoding
- p0x, p0y  out  11 signed  player 0 position
- p1x, p1y  out  11 signed  player 1 position
- grant  out  2  one-hot, one-cycle pulse: player whose move was committed
- blocked  out  1  one-cycle pulse: selected move refused for collision
- window  out  1  high while the update window is open

## Operation
- Window flag: reset value 0. EOF sets it and SOF clears it. If EOF and SOF arrive in the same cycle, SOF wins and the flag is 0.
- FSM states: IDLE, COUNT, EVAL, COMMIT. Reset state is IDLE.
- IDLE -> COUNT when the window opens. The prescaler counter clears to 0.
- COUNT: the counter increments each cycle. At STEP_DIV-1 (the tick), the counter goes to 0 and the FSM goes to EVAL. If the window closes, the FSM goes to IDLE.
- Key decode: exactly one bit low gives the matching single-axis move. All bits high gives no request. Any other pattern is handled per the Configuration section.
- EVAL: keys are sampled this cycle. The arbiter selects a requester. If only one player requests, that player is selected. If both request, the player pointed to by rr_ptr is selected. With no requester, the FSM returns to COUNT.
- Candidate = current position ± STEP per requested axis.
  - Any axis that would leave its legal range keeps its current value.
  - Arithmetic is signed 12-bit, so there is no wrap.
- COMMIT, evaluated in priority order:
  - Candidate equals current position: no write, no pulse.
  - Candidate overlaps the other player's current position: no write, blocked=1.
  - Otherwise: position written, grant[sel]=1.
- rr_ptr (reset 0) switches to the other player whenever a selection reaches COMMIT, whatever the outcome.
- After COMMIT, the FSM goes to COUNT if the window is still open, else to IDLE.
- Reset values:
  - p0=(P0_X0,P0_Y0), p1=(P1_X0,P1_Y0).
  - grant=0, blocked=0, window=0.
  - Counter=0, rr_ptr=0.
- Reset mid-operation: asynchronous, so all state goes to reset values immediately and any pending commit is discarded.

## Timing
- Tick in cycle N: keys sampled in cycle N+1 (EVAL). Positions, grant and blocked are registered at the end of cycle N+2 and visible from N+3.
- At most one position update per tick. Tick spacing is STEP_DIV+2 cycles while a request is pending, STEP_DIV+1 otherwise.
- SOF during EVAL or COMMIT: the EVAL/COMMIT sequence completes atomically. Outputs are stable from SOF+3 cycles until the next window.
- grant and blocked are never high in the same cycle. Positions never change outside COMMIT.

## Configuration
- MOVE_SCHED_DIAG_EN defined:
  - Exactly one horizontal bit plus one vertical bit low gives a diagonal move; both axes move by STEP.
  - Each axis is clamped independently.
  - Opposite pairs (right+left, or up+down) and three or more bits low give no request.
- Undefined: any pattern other than exactly one bit low gives no request.

## Test plan
- Reset, then idle frames with all keys high -> p0=(100,300), p1=(700,300), grant never pulses, window follows EOF/SOF.
- key0=4'b1110 held for one window of 3 ticks -> p0x 100→103, grant=2'b01 three times, p1 unchanged. After SOF, no further change.
- p1 at x=799 with key1=4'b1110 -> p1x stays 799, no grant, no blocked. Likewise p0 at y=0 with key0=4'b1011 -> p0y stays 0.
- Both players pressing every tick -> grants alternate 01,10,01,…, starting with player 0 after reset.
- p0=(100,300), p1=(132,300), key0 right -> blocked pulses, p0 unchanged. Player 1 moving right next is granted.
- key0=4'b1100: with MOVE_SCHED_DIAG_EN, p0 goes to (101,301) per tick. Without it, no move. With 4'b0110 (right+left), no move in either build.
